// File: rtl/l2_cache_pkg.sv
// Shared L2 cache constants and the per-set tag entry layout.
package l2_cache_pkg;

  localparam int L2_ADDR_WIDTH  = 32;
  localparam int L2_INDEX_WIDTH = 9;
  localparam int L2_LINE_BITS   = 5;
  localparam int L2_TAG_BITS    = L2_ADDR_WIDTH - L2_INDEX_WIDTH - L2_LINE_BITS;

  typedef struct packed {
    logic [L2_TAG_BITS-1:0] tag;
    logic                   dirty;
    logic                   valid;
  } l2_tag_entry_t;

endpackage

// File: rtl/l2_tag_storage.sv
// Resettable flop array of tag entries with two write ports and two
// asynchronous read ports; port B's write lands last on a same-index collision.
module l2_tag_storage
  import l2_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = L2_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we_a_i,
  input  logic [INDEX_WIDTH-1:0] addr_a_i,
  input  l2_tag_entry_t          wdata_a_i,
  input  logic                   we_b_i,
  input  logic [INDEX_WIDTH-1:0] addr_b_i,
  input  l2_tag_entry_t          wdata_b_i,
  output l2_tag_entry_t          rdata_a_o,
  output l2_tag_entry_t          rdata_b_o
);

  localparam int DEPTH = 2 ** INDEX_WIDTH;

  l2_tag_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (we_a_i) mem_q[addr_a_i] <= wdata_a_i;
      // Issued after A so B overwrites A when both target one index.
      if (we_b_i) mem_q[addr_b_i] <= wdata_b_i;
    end
  end

  assign rdata_a_o = mem_q[addr_a_i];
  assign rdata_b_o = mem_q[addr_b_i];

endmodule

// File: rtl/l2_tag_array.sv
// Dual-port tag/state store for one L2 way with registered lookup and hit.
// Define L2_TAG_WRITE_BYPASS_EN for write-first forwarding (default read-first).
module l2_tag_array
  import l2_cache_pkg::*;
#(
  parameter int TAG_BITS    = L2_TAG_BITS,
  parameter int INDEX_WIDTH = L2_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] addr_a,
  input  logic [TAG_BITS-1:0]    tag_a,
  input  logic                   dirty_a_i,
  input  logic                   valid_a_i,
  input  logic                   we_a,
  input  logic [INDEX_WIDTH-1:0] addr_b,
  input  logic [TAG_BITS-1:0]    tag_b,
  input  logic                   dirty_b_i,
  input  logic                   valid_b_i,
  input  logic                   we_b,
  output logic [TAG_BITS-1:0]    q_a,
  output logic [TAG_BITS-1:0]    q_b,
  output logic                   dirty_a_o,
  output logic                   dirty_b_o,
  output logic                   valid_a_o,
  output logic                   valid_b_o,
  output logic                   hit_a,
  output logic                   hit_b
);

  l2_tag_entry_t wdata_a, wdata_b, rdata_a, rdata_b;
  l2_tag_entry_t ent_a_d, ent_b_d, ent_a_q, ent_b_q;
  logic [TAG_BITS-1:0] ltag_a_q, ltag_b_q;

  assign wdata_a = '{tag: tag_a, dirty: dirty_a_i, valid: valid_a_i};
  assign wdata_b = '{tag: tag_b, dirty: dirty_b_i, valid: valid_b_i};

  l2_tag_storage #(
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_storage (
    .clk       (clk),
    .reset     (reset),
    .we_a_i    (we_a),
    .addr_a_i  (addr_a),
    .wdata_a_i (wdata_a),
    .we_b_i    (we_b),
    .addr_b_i  (addr_b),
    .wdata_b_i (wdata_b),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b)
  );

`ifdef L2_TAG_WRITE_BYPASS_EN
  // Forward same-cycle writes; B is checked first so it wins a double write.
  always_comb begin
    ent_a_d = rdata_a;
    if (we_b && (addr_b == addr_a))      ent_a_d = wdata_b;
    else if (we_a)                       ent_a_d = wdata_a;
  end

  always_comb begin
    ent_b_d = rdata_b;
    if (we_b)                            ent_b_d = wdata_b;
    else if (we_a && (addr_a == addr_b)) ent_b_d = wdata_a;
  end
`else
  assign ent_a_d = rdata_a;
  assign ent_b_d = rdata_b;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_a_q  <= '0;
      ent_b_q  <= '0;
      ltag_a_q <= '0;
      ltag_b_q <= '0;
    end else begin
      ent_a_q  <= ent_a_d;
      ent_b_q  <= ent_b_d;
      ltag_a_q <= tag_a;
      ltag_b_q <= tag_b;
    end
  end

  assign q_a       = ent_a_q.tag;
  assign q_b       = ent_b_q.tag;
  assign dirty_a_o = ent_a_q.dirty;
  assign dirty_b_o = ent_b_q.dirty;
  assign valid_a_o = ent_a_q.valid;
  assign valid_b_o = ent_b_q.valid;
  assign hit_a     = ent_a_q.valid & (ent_a_q.tag == ltag_a_q);
  assign hit_b     = ent_b_q.valid & (ent_b_q.tag == ltag_b_q);

endmodule

// File: tb/tb_l2_tag_array.sv
// Scoreboard bench for l2_tag_array: a behavioural tag store predicts each
// port's {q, dirty, valid, hit} one cycle after the lookup.
module tb_l2_tag_array;

  localparam int TW    = 18;
  localparam int IW    = 9;
  localparam int DEPTH = 2 ** IW;
  localparam int W     = TW + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] addr_a, addr_b;
  logic [TW-1:0] tag_a, tag_b;
  logic          dirty_a_i, valid_a_i, we_a;
  logic          dirty_b_i, valid_b_i, we_b;
  logic [TW-1:0] q_a, q_b;
  logic          dirty_a_o, dirty_b_o, valid_a_o, valid_b_o, hit_a, hit_b;

  l2_tag_array dut (
    .clk       (clk),
    .reset     (reset),
    .addr_a    (addr_a),
    .tag_a     (tag_a),
    .dirty_a_i (dirty_a_i),
    .valid_a_i (valid_a_i),
    .we_a      (we_a),
    .addr_b    (addr_b),
    .tag_b     (tag_b),
    .dirty_b_i (dirty_b_i),
    .valid_b_i (valid_b_i),
    .we_b      (we_b),
    .q_a       (q_a),
    .q_b       (q_b),
    .dirty_a_o (dirty_a_o),
    .dirty_b_o (dirty_b_o),
    .valid_a_o (valid_a_o),
    .valid_b_o (valid_b_o),
    .hit_a     (hit_a),
    .hit_b     (hit_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model state and scoreboard
  logic [TW+1:0] model_mem [DEPTH];
  logic [W-1:0]  exp_q [$];
  int            checks   = 0;
  int            failures = 0;

  task automatic check_val(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got q=%h d=%b v=%b hit=%b, expected q=%h d=%b v=%b hit=%b", name,
               got[W-1:3], got[2], got[1], got[0], exp[W-1:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [W-1:0] predict(input logic rst, input logic [IW-1:0] addr,
                                           input logic [TW-1:0] tag);
    logic [TW+1:0] e;
    if (rst) return '0;
    e = model_mem[addr];
`ifdef L2_TAG_WRITE_BYPASS_EN
    if (we_b && addr_b == addr)      e = {tag_b, dirty_b_i, valid_b_i};
    else if (we_a && addr_a == addr) e = {tag_a, dirty_a_i, valid_a_i};
`endif
    return {e, (e[0] && (e[TW+1:2] == tag))};
  endfunction

  // driver: one cycle of stimulus, then score both ports after the edge
  task automatic drive(input string name, input logic rst,
                       input logic [IW-1:0] aa, input logic [TW-1:0] ta,
                       input logic da, input logic va, input logic wa,
                       input logic [IW-1:0] ab, input logic [TW-1:0] tb_,
                       input logic db, input logic vb, input logic wb);
    @(negedge clk);
    reset = rst;
    addr_a = aa; tag_a = ta;  dirty_a_i = da; valid_a_i = va; we_a = wa;
    addr_b = ab; tag_b = tb_; dirty_b_i = db; valid_b_i = vb; we_b = wb;
    exp_q.push_back(predict(rst, aa, ta));
    exp_q.push_back(predict(rst, ab, tb_));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else begin
      if (wa) model_mem[aa] = {ta, da, va};
      if (wb) model_mem[ab] = {tb_, db, vb};
    end
    #1;
    check_val({name, "_a"}, {q_a, dirty_a_o, valid_a_o, hit_a}, exp_q.pop_front());
    check_val({name, "_b"}, {q_b, dirty_b_o, valid_b_o, hit_b}, exp_q.pop_front());
  endtask

  task automatic idle(input string name, input logic [IW-1:0] aa, input logic [TW-1:0] ta,
                      input logic [IW-1:0] ab, input logic [TW-1:0] tb_);
    drive(name, 1'b0, aa, ta, 1'b0, 1'b0, 1'b0, ab, tb_, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    // 1: reset, then read both ends of the index range
    drive("reset", 1'b1, 9'd0, 18'h0, 1'b0, 1'b0, 1'b1, 9'd0, 18'h0, 1'b0, 1'b0, 1'b1);
    idle("rd_lo_hi", 9'd0, 18'h0, 9'd511, 18'h0);
    idle("rd_hi_lo", 9'd511, 18'h0, 9'd0, 18'h0);
    // 2: write idx 5 then hit / miss
    drive("wr5", 1'b0, 9'd5, 18'h2ABCD, 1'b1, 1'b1, 1'b1, 9'd6, 18'h0, 1'b0, 1'b0, 1'b0);
    idle("hit5", 9'd5, 18'h2ABCD, 9'd5, 18'h2ABCD);
    idle("miss5", 9'd5, 18'h00001, 9'd5, 18'h00001);
    // 3: double write to idx 7, B wins
    drive("wr7", 1'b0, 9'd7, 18'h11, 1'b0, 1'b1, 1'b1, 9'd7, 18'h22, 1'b0, 1'b1, 1'b1);
    idle("rd7", 9'd7, 18'h22, 9'd7, 18'h11);
    // 4: cross-port read during write
    drive("pre3", 1'b0, 9'd0, 18'h0, 1'b0, 1'b0, 1'b0, 9'd3, 18'h10, 1'b0, 1'b1, 1'b1);
    drive("xrw3", 1'b0, 9'd3, 18'h33, 1'b0, 1'b1, 1'b1, 9'd3, 18'h33, 1'b0, 1'b0, 1'b0);
    drive("srw3", 1'b0, 9'd3, 18'h44, 1'b1, 1'b1, 1'b1, 9'd8, 18'h0, 1'b0, 1'b0, 1'b0);
    idle("rd3", 9'd3, 18'h44, 9'd3, 18'h33);
    // 5: reset wipes state and overrides a same-cycle write
    drive("wr9", 1'b0, 9'd9, 18'h99, 1'b0, 1'b1, 1'b1, 9'd10, 18'h0, 1'b0, 1'b0, 1'b0);
    drive("rst_wr", 1'b1, 9'd9, 18'h99, 1'b1, 1'b1, 1'b1, 9'd11, 18'h5, 1'b0, 1'b1, 1'b1);
    idle("rd9", 9'd9, 18'h99, 9'd11, 18'h5);
    // 6: stored but invalid entry never hits
    drive("wr4", 1'b0, 9'd4, 18'h44, 1'b0, 1'b0, 1'b1, 9'd12, 18'h0, 1'b0, 1'b0, 1'b0);
    idle("rd4", 9'd4, 18'h44, 9'd4, 18'h44);
    // random traffic over a narrow index window to force collisions
    for (int n = 0; n < 300; n++) begin
      drive("rand", 1'b0,
            IW'($urandom_range(0, 7)), TW'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            IW'($urandom_range(0, 7)), TW'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
